// File: rtl/icache_dm_pkg.sv
// Shared definitions for the direct-mapped instruction cache.
//   XLEN            : core data/address width
//   ICACHE_INDEX_W  : default number of index bits (2^N one-word lines)
//   icache_state_t  : controller states (IDLE lookup, MISS fill, RESP return)
//   icache_tag_w()  : tag width for a given flash address width and index width
package icache_dm_pkg;

  localparam int XLEN           = 32;
  localparam int ICACHE_INDEX_W = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MISS = 2'd1,
    RESP = 2'd2
  } icache_state_t;

  // Lines are one 32-bit word, so the two byte-offset bits sit below the index.
  function automatic int icache_tag_w(input int addr_w, input int index_w);
    return addr_w - index_w - 2;
  endfunction

endpackage

// File: rtl/icache_dm_if.sv
// Bus interfaces of the instruction cache. Signal suffixes are as seen from
// the cache (_i into the cache, _o out of it).
//   icache_fetch_if : core fetch port (req/addr in, rvalid/rdata out)
//     master = core, slave = cache
//   icache_mem_if   : flash-reader port (req/addr out, rvalid/rdata/init in)
//     master = cache, slave = flash reader
interface icache_fetch_if;
  logic                             instr_req_i;
  logic [icache_dm_pkg::XLEN-1:0]   instr_addr_i;
  logic                             instr_rvalid_o;
  logic [icache_dm_pkg::XLEN-1:0]   instr_rdata_o;

  modport master (output instr_req_i, instr_addr_i,
                  input  instr_rvalid_o, instr_rdata_o);
  modport slave  (input  instr_req_i, instr_addr_i,
                  output instr_rvalid_o, instr_rdata_o);
endinterface

interface icache_mem_if;
  logic                             mem_req_o;
  logic [icache_dm_pkg::XLEN-1:0]   mem_addr_o;
  logic                             mem_rvalid_i;
  logic [icache_dm_pkg::XLEN-1:0]   mem_rdata_i;
  logic                             mem_init_i;

  modport master (output mem_req_o, mem_addr_o,
                  input  mem_rvalid_i, mem_rdata_i, mem_init_i);
  modport slave  (input  mem_req_o, mem_addr_o,
                  output mem_rvalid_i, mem_rdata_i, mem_init_i);
endinterface

// File: rtl/icache_tag_data.sv
// Valid/tag/data storage for the direct-mapped cache.
//   clk_i, arstn_i      : clock, async active-low reset (valid bits only)
//   rd_idx_i            : combinational read index
//   rd_valid_o/tag/data : line contents at rd_idx_i
//   we_i, wr_*          : line write (tag, data and the new valid bit)
//   flush_i             : clear every valid bit
// Tag and data are plain register arrays without reset; only the valid
// vector is reset so a cold cache never reports a hit.
module icache_tag_data #(
  parameter int INDEX_W = 6,
  parameter int TAG_W   = 16,
  parameter int DATA_W  = 32
) (
  input  logic               clk_i,
  input  logic               arstn_i,
  input  logic [INDEX_W-1:0] rd_idx_i,
  output logic               rd_valid_o,
  output logic [TAG_W-1:0]   rd_tag_o,
  output logic [DATA_W-1:0]  rd_data_o,
  input  logic               we_i,
  input  logic [INDEX_W-1:0] wr_idx_i,
  input  logic [TAG_W-1:0]   wr_tag_i,
  input  logic [DATA_W-1:0]  wr_data_i,
  input  logic               wr_valid_i,
  input  logic               flush_i
);

  localparam int LINES = 1 << INDEX_W;

  logic [LINES-1:0]  valid_q, valid_d;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [DATA_W-1:0] data_q [LINES];

  // A write may carry valid=0 (fill overlapped by a flush); it still must
  // clear the bit because the tag/data underneath have been replaced.
  always_comb begin
    valid_d = valid_q;
    if (flush_i) valid_d = '0;
    if (we_i)    valid_d[wr_idx_i] = wr_valid_i;
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) valid_q <= '0;
    else          valid_q <= valid_d;
  end

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      tag_q[wr_idx_i]  <= wr_tag_i;
      data_q[wr_idx_i] <= wr_data_i;
    end
  end

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_data_o  = data_q[rd_idx_i];

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache in front of the SPI flash reader.
//   clk_i, arstn_i : clock, async active-low reset
//   fetch          : core fetch port (icache_fetch_if.slave)
//   mem            : flash reader port (icache_mem_if.master)
//   flush_i        : one-cycle pulse, invalidates all lines (fence.i)
//   hit_cnt_o      : saturating hit counter
//   miss_cnt_o     : saturating miss counter
// Hits return the word one cycle after the request and the controller stays
// in IDLE, so back-to-back hits stream at one word per cycle. A miss holds a
// single-word flash read until the data returns, then answers from RESP.
module icache_dm
  import icache_dm_pkg::*;
#(
  parameter int INDEX_W = ICACHE_INDEX_W,
  parameter int ADDR_W  = 24,
  parameter int CNT_W   = 32
) (
  input  logic              clk_i,
  input  logic              arstn_i,
  icache_fetch_if.slave     fetch,
  icache_mem_if.master      mem,
  input  logic              flush_i,
  output logic [CNT_W-1:0]  hit_cnt_o,
  output logic [CNT_W-1:0]  miss_cnt_o
);

  localparam int TAG_W = icache_tag_w(ADDR_W, INDEX_W);
  localparam int LO    = INDEX_W + 2;

  icache_state_t     state_q, state_d;
  logic [XLEN-3:0]   waddr_q, waddr_d;     // latched word address of the miss
  logic              rvalid_q, rvalid_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;
  logic [CNT_W-1:0]  hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]  miss_cnt_q, miss_cnt_d;
  logic              abort_q, abort_d;     // core dropped req during the fill
  logic              nofill_q, nofill_d;   // flush seen during the fill

  logic [INDEX_W-1:0] lk_idx;
  logic [TAG_W-1:0]   lk_tag;
  logic               rd_valid;
  logic [TAG_W-1:0]   rd_tag;
  logic [XLEN-1:0]    rd_data;
  logic               hit;
  logic               we;
  logic               wr_valid;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign lk_idx = fetch.instr_addr_i[LO-1:2];
  assign lk_tag = fetch.instr_addr_i[ADDR_W-1:LO];
  assign hit    = rd_valid && (rd_tag == lk_tag);

  icache_tag_data #(
    .INDEX_W (INDEX_W),
    .TAG_W   (TAG_W),
    .DATA_W  (XLEN)
  ) u_tag_data (
    .clk_i      (clk_i),
    .arstn_i    (arstn_i),
    .rd_idx_i   (lk_idx),
    .rd_valid_o (rd_valid),
    .rd_tag_o   (rd_tag),
    .rd_data_o  (rd_data),
    .we_i       (we),
    .wr_idx_i   (waddr_q[INDEX_W-1:0]),
    .wr_tag_i   (waddr_q[ADDR_W-3:INDEX_W]),
    .wr_data_i  (mem.mem_rdata_i),
    .wr_valid_i (wr_valid),
    .flush_i    (flush_i)
  );

  always_comb begin
    state_d    = state_q;
    waddr_d    = waddr_q;
    rvalid_d   = 1'b0;
    rdata_d    = '0;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    abort_d    = abort_q;
    nofill_d   = nofill_q;
    we         = 1'b0;
    wr_valid   = 1'b0;
    unique case (state_q)
      IDLE: begin
        abort_d  = 1'b0;
        nofill_d = 1'b0;
        if (fetch.instr_req_i) begin
          // A lookup racing a flush must not use the lines being cleared.
          if (hit && !flush_i) begin
            rvalid_d  = 1'b1;
            rdata_d   = rd_data;
            hit_cnt_d = sat_inc(hit_cnt_q);
          end else begin
            waddr_d    = fetch.instr_addr_i[XLEN-1:2];
            miss_cnt_d = sat_inc(miss_cnt_q);
            state_d    = MISS;
          end
        end
      end
      MISS: begin
        if (!fetch.instr_req_i) abort_d  = 1'b1;
        if (flush_i)            nofill_d = 1'b1;
        if (mem.mem_rvalid_i) begin
          we       = 1'b1;
          wr_valid = !(nofill_q || flush_i);
          if (abort_q || !fetch.instr_req_i) begin
            state_d = IDLE;
          end else begin
            state_d  = RESP;
            rvalid_d = 1'b1;
            rdata_d  = mem.mem_rdata_i;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q    <= IDLE;
      waddr_q    <= '0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      abort_q    <= 1'b0;
      nofill_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      waddr_q    <= waddr_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      abort_q    <= abort_d;
      nofill_q   <= nofill_d;
    end
  end

  // Request is decoded straight from the state flop so an async reset drops
  // it immediately; gating with init keeps the reader idle until it is ready.
  assign mem.mem_req_o        = (state_q == MISS) && mem.mem_init_i;
  assign mem.mem_addr_o       = {waddr_q, 2'b00};
  assign fetch.instr_rvalid_o = rvalid_q;
  assign fetch.instr_rdata_o  = rdata_q;
  assign hit_cnt_o            = hit_cnt_q;
  assign miss_cnt_o           = miss_cnt_q;

endmodule

// File: tb/tb_icache_dm.sv
module tb_icache_dm;

  logic        clk = 1'b0;
  logic        arstn;
  logic        flush;
  logic [31:0] hit_cnt, miss_cnt;

  icache_fetch_if f_if();
  icache_mem_if   m_if();

  icache_dm #(.INDEX_W(6), .ADDR_W(24), .CNT_W(32)) dut (
    .clk_i(clk), .arstn_i(arstn), .fetch(f_if), .mem(m_if),
    .flush_i(flush), .hit_cnt_o(hit_cnt), .miss_cnt_o(miss_cnt)
  );

  // Narrow-counter instance with a zero-latency flash for saturation.
  icache_fetch_if s_f();
  icache_mem_if   s_m();
  logic           s_flush;
  logic [1:0]     s_hit, s_miss;
  assign s_m.mem_rvalid_i = s_m.mem_req_o;
  assign s_m.mem_rdata_i  = 32'h0000_0013;
  assign s_m.mem_init_i   = 1'b1;

  icache_dm #(.INDEX_W(6), .ADDR_W(24), .CNT_W(2)) dut_sat (
    .clk_i(clk), .arstn_i(arstn), .fetch(s_f), .mem(s_m),
    .flush_i(s_flush), .hit_cnt_o(s_hit), .miss_cnt_o(s_miss)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- flash stub ----------------
  int          stub_lat      = 150;
  int          stub_cnt      = 0;
  int          stub_fills    = 0;
  int          stub_addr_err = 0;
  logic [31:0] stub_addr     = '0;

  function automatic logic [31:0] flash_word(input logic [31:0] a);
    if (a == 32'h100) return 32'h0050_0093;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  always @(negedge clk) begin
    if (m_if.mem_rvalid_i) begin
      m_if.mem_rvalid_i = 1'b0;
      m_if.mem_rdata_i  = '0;
      stub_cnt = 0;
    end else if (m_if.mem_req_o) begin
      if (stub_cnt == 0) stub_addr = m_if.mem_addr_o;
      else if (m_if.mem_addr_o !== stub_addr) stub_addr_err++;
      stub_cnt++;
      if (stub_cnt >= stub_lat) begin
        m_if.mem_rvalid_i = 1'b1;
        m_if.mem_rdata_i  = flash_word(stub_addr);
        stub_fills++;
      end
    end else begin
      stub_cnt = 0;
    end
  end

  // ---------------- reference model ----------------
  bit          m_valid [64];
  logic [15:0] m_tag   [64];
  logic [31:0] m_data  [64];
  int          exp_hit  = 0;
  int          exp_miss = 0;

  function automatic void model_clear();
    for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
  endfunction

  // One core access: line index is addr[7:2], tag is addr[23:8].
  function automatic void model_access(input logic [31:0] a, input bit fl_before,
                                       input bit fl_mid, output logic [31:0] d,
                                       output bit h);
    int idx;
    idx = int'(a[7:2]);
    if (fl_before) model_clear();
    h = m_valid[idx] && (m_tag[idx] == a[23:8]);
    if (h) begin
      d = m_data[idx];
      exp_hit++;
    end else begin
      d = flash_word({a[31:2], 2'b00});
      exp_miss++;
      if (fl_mid) model_clear();
      m_tag[idx]   = a[23:8];
      m_data[idx]  = d;
      m_valid[idx] = !fl_mid;
    end
  endfunction

  // Drives one fetch starting at a negedge; returns at the negedge rvalid is seen.
  task automatic fetch(input logic [31:0] a, input int flush_at, output logic [31:0] dat,
                       output int cyc, output bit got, output bit saw_req);
    f_if.instr_req_i  = 1'b1;
    f_if.instr_addr_i = a;
    got = 1'b0; saw_req = 1'b0; cyc = 0; dat = '0;
    if (flush_at == 0) flush = 1'b1;
    while (!got && cyc < 2000) begin
      @(negedge clk);
      flush = 1'b0;
      cyc++;
      if (m_if.mem_req_o) saw_req = 1'b1;
      if (f_if.instr_rvalid_o) begin
        got = 1'b1;
        dat = f_if.instr_rdata_o;
      end else if (cyc == flush_at) begin
        flush = 1'b1;
      end
    end
    f_if.instr_req_i = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    arstn = 1'b0; flush = 1'b0; s_flush = 1'b0;
    f_if.instr_req_i = 1'b0; f_if.instr_addr_i = '0;
    s_f.instr_req_i = 1'b0;  s_f.instr_addr_i = '0;
    m_if.mem_rvalid_i = 1'b0; m_if.mem_rdata_i = '0; m_if.mem_init_i = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (f_if.instr_rvalid_o !== 1'b0 || f_if.instr_rdata_o !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_fetch: rvalid=%b rdata=%h required 0/0", f_if.instr_rvalid_o, f_if.instr_rdata_o);
    end
    n_checks++;
    if (m_if.mem_req_o !== 1'b0 || m_if.mem_addr_o !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_mem: req=%b addr=%h required 0/0", m_if.mem_req_o, m_if.mem_addr_o);
    end
    n_checks++;
    if (hit_cnt !== 32'h0 || miss_cnt !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_cnt: hit=%0d miss=%0d required 0/0", hit_cnt, miss_cnt);
    end
    arstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_cold_miss();
    logic [31:0] dat, ed; int cyc; bit got, sr, eh;
    stub_lat = 150;
    model_access(32'h100, 0, 0, ed, eh);
    fetch(32'h100, -1, dat, cyc, got, sr);
    n_checks++;
    if (!got || dat !== 32'h0050_0093) begin
      n_fail++;
      $display("FAIL cold_data: got=%b data=%h required %h", got, dat, 32'h0050_0093);
    end
    n_checks++;
    if (cyc !== 151) begin
      n_fail++;
      $display("FAIL cold_latency: rvalid after %0d cycles, required 151", cyc);
    end
    n_checks++;
    if (stub_addr !== 32'h100 || stub_addr_err !== 0 || !sr) begin
      n_fail++;
      $display("FAIL cold_memaddr: addr=%h unstable=%0d req_seen=%b required 100/0/1", stub_addr, stub_addr_err, sr);
    end
    @(negedge clk);
    n_checks++;
    if (f_if.instr_rvalid_o !== 1'b0 || f_if.instr_rdata_o !== 32'h0) begin
      n_fail++;
      $display("FAIL cold_pulse: rvalid=%b rdata=%h required 0/0", f_if.instr_rvalid_o, f_if.instr_rdata_o);
    end
    n_checks++;
    if (miss_cnt !== 32'(exp_miss) || hit_cnt !== 32'(exp_hit)) begin
      n_fail++;
      $display("FAIL cold_cnt: hit=%0d miss=%0d required %0d/%0d", hit_cnt, miss_cnt, exp_hit, exp_miss);
    end
  endtask

  task automatic test_hit_stream();
    logic [31:0] dat, ed; int cyc; bit got, sr, eh;
    logic [31:0] addrs [3];
    int req_seen;
    addrs[0] = 32'h100; addrs[1] = 32'h104; addrs[2] = 32'h108;
    stub_lat = 8;
    for (int i = 1; i < 3; i++) begin
      model_access(addrs[i], 0, 0, ed, eh);
      fetch(addrs[i], -1, dat, cyc, got, sr);
      @(negedge clk);
    end
    req_seen = 0;
    f_if.instr_req_i  = 1'b1;
    f_if.instr_addr_i = addrs[0];
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      model_access(addrs[i], 0, 0, ed, eh);
      if (m_if.mem_req_o) req_seen++;
      n_checks++;
      if (f_if.instr_rvalid_o !== 1'b1 || f_if.instr_rdata_o !== ed || !eh) begin
        n_fail++;
        $display("FAIL stream_%0d: rvalid=%b data=%h required 1/%h", i, f_if.instr_rvalid_o, f_if.instr_rdata_o, ed);
      end
      if (i < 2) f_if.instr_addr_i = addrs[i+1];
      else       f_if.instr_req_i  = 1'b0;
    end
    @(negedge clk);
    n_checks++;
    if (req_seen !== 0 || m_if.mem_req_o !== 1'b0 || f_if.instr_rvalid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL stream_quiet: mem_req cycles=%0d rvalid=%b required 0/0", req_seen, f_if.instr_rvalid_o);
    end
    n_checks++;
    if (hit_cnt !== 32'(exp_hit) || miss_cnt !== 32'(exp_miss)) begin
      n_fail++;
      $display("FAIL stream_cnt: hit=%0d miss=%0d required %0d/%0d", hit_cnt, miss_cnt, exp_hit, exp_miss);
    end
  endtask

  task automatic test_conflict();
    logic [31:0] dat, ed; int cyc; bit got, sr, eh;
    logic [31:0] seq [2];
    seq[0] = 32'h200; seq[1] = 32'h100;
    for (int i = 0; i < 2; i++) begin
      model_access(seq[i], 0, 0, ed, eh);
      fetch(seq[i], -1, dat, cyc, got, sr);
      n_checks++;
      if (!got || dat !== ed || sr !== 1'b1 || eh) begin
        n_fail++;
        $display("FAIL conflict_%h: data=%h req_seen=%b required %h/1", seq[i], dat, sr, ed);
      end
      @(negedge clk);
    end
    n_checks++;
    if (miss_cnt !== 32'(exp_miss)) begin
      n_fail++;
      $display("FAIL conflict_cnt: miss=%0d required %0d", miss_cnt, exp_miss);
    end
  endtask

  task automatic test_flush();
    logic [31:0] dat, ed; int cyc; bit got, sr, eh;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    model_clear();
    model_access(32'h100, 0, 0, ed, eh);
    fetch(32'h100, -1, dat, cyc, got, sr);
    n_checks++;
    if (!got || dat !== ed || sr !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_idle: data=%h req_seen=%b required %h/1", dat, sr, ed);
    end
    @(negedge clk);
    // Flush raised in the very cycle of the lookup of a valid line.
    model_access(32'h100, 1, 0, ed, eh);
    fetch(32'h100, 0, dat, cyc, got, sr);
    n_checks++;
    if (!got || dat !== ed || sr !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_same_cycle: data=%h req_seen=%b required %h/1", dat, sr, ed);
    end
    @(negedge clk);
  endtask

  task automatic test_flush_during_miss();
    logic [31:0] dat, ed; int cyc; bit got, sr, eh;
    stub_lat = 40;
    model_access(32'h40, 0, 1, ed, eh);
    fetch(32'h40, 20, dat, cyc, got, sr);
    n_checks++;
    if (!got || dat !== ed) begin
      n_fail++;
      $display("FAIL flush_mid_data: got=%b data=%h required %h", got, dat, ed);
    end
    @(negedge clk);
    model_access(32'h40, 0, 0, ed, eh);
    fetch(32'h40, -1, dat, cyc, got, sr);
    n_checks++;
    if (!got || dat !== ed || sr !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_mid_refetch: data=%h req_seen=%b required %h/1", dat, sr, ed);
    end
    @(negedge clk);
  endtask

  task automatic test_abort();
    logic [31:0] dat, ed; int cyc; bit got, sr, eh;
    int fills0, rv_seen, waited;
    stub_lat = 30;
    model_access(32'h80, 0, 0, ed, eh);
    fills0 = stub_fills; rv_seen = 0; waited = 0;
    f_if.instr_req_i = 1'b1; f_if.instr_addr_i = 32'h80;
    repeat (3) @(negedge clk);
    f_if.instr_req_i = 1'b0;
    while (stub_fills == fills0 && waited < 500) begin
      @(negedge clk);
      waited++;
      if (f_if.instr_rvalid_o) rv_seen++;
    end
    repeat (3) begin
      @(negedge clk);
      if (f_if.instr_rvalid_o) rv_seen++;
    end
    n_checks++;
    if (stub_fills == fills0 || rv_seen !== 0) begin
      n_fail++;
      $display("FAIL abort_fill: fill_done=%b rvalid_cycles=%0d required 1/0", stub_fills != fills0, rv_seen);
    end
    model_access(32'h80, 0, 0, ed, eh);
    fetch(32'h80, -1, dat, cyc, got, sr);
    n_checks++;
    if (!got || dat !== ed || cyc !== 1 || sr !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_rehit: data=%h cycles=%0d req_seen=%b required %h/1/0", dat, cyc, sr, ed);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_miss();
    logic [31:0] dat, ed; int cyc; bit got, sr, eh;
    stub_lat = 150;
    f_if.instr_req_i = 1'b1; f_if.instr_addr_i = 32'h300;
    repeat (10) @(negedge clk);
    n_checks++;
    if (m_if.mem_req_o !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmiss_pre: mem_req=%b required 1", m_if.mem_req_o);
    end
    #2 arstn = 1'b0;
    #1;
    n_checks++;
    if (m_if.mem_req_o !== 1'b0 || hit_cnt !== 32'h0 || miss_cnt !== 32'h0 || f_if.instr_rvalid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmiss_async: req=%b hit=%0d miss=%0d rvalid=%b required all 0", m_if.mem_req_o, hit_cnt, miss_cnt, f_if.instr_rvalid_o);
    end
    f_if.instr_req_i = 1'b0;
    @(negedge clk);
    arstn = 1'b1;
    model_clear(); exp_hit = 0; exp_miss = 0;
    @(negedge clk);
    stub_lat = 6;
    model_access(32'h100, 0, 0, ed, eh);
    fetch(32'h100, -1, dat, cyc, got, sr);
    n_checks++;
    if (!got || dat !== ed || sr !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmiss_invalid: data=%h req_seen=%b required %h/1", dat, sr, ed);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [31:0] a, dat, ed; int cyc, fat; bit got, sr, eh, fb, fm;
    logic [7:0]  hi; logic [15:0] tg; logic [5:0] ix;
    int errs;
    errs = 0;
    for (int i = 0; i < 40; i++) begin
      stub_lat = $urandom_range(3, 12);
      hi = 8'($urandom);
      case ($urandom_range(0, 2))
        0: tg = 16'h0001;
        1: tg = 16'h0002;
        default: tg = 16'h0A0B;
      endcase
      case ($urandom_range(0, 3))
        0: ix = 6'd0;
        1: ix = 6'd1;
        2: ix = 6'd5;
        default: ix = 6'd63;
      endcase
      a  = {hi, tg, ix, 2'b00};
      fb = ($urandom_range(0, 7) == 0);
      fm = !fb && ($urandom_range(0, 4) == 0);
      fat = fb ? 0 : (fm ? int'($urandom_range(1, stub_lat)) : -1);
      model_access(a, fb, fm, ed, eh);
      fetch(a, fat, dat, cyc, got, sr);
      n_checks++;
      if (!got || dat !== ed || sr !== !eh || (eh && cyc !== 1)) begin
        n_fail++; errs++;
        if (errs < 6)
          $display("FAIL rand_%0d addr=%h: data=%h req_seen=%b cycles=%0d required %h hit=%b", i, a, dat, sr, cyc, ed, eh);
      end
      @(negedge clk);
    end
    n_checks++;
    if (hit_cnt !== 32'(exp_hit) || miss_cnt !== 32'(exp_miss) || stub_addr_err !== 0) begin
      n_fail++;
      $display("FAIL rand_cnt: hit=%0d miss=%0d addr_unstable=%0d required %0d/%0d/0", hit_cnt, miss_cnt, stub_addr_err, exp_hit, exp_miss);
    end
  endtask

  task automatic test_saturation();
    s_f.instr_addr_i = 32'h10;
    s_f.instr_req_i  = 1'b1;
    repeat (12) @(negedge clk);
    n_checks++;
    if (s_hit !== 2'd3 || s_miss !== 2'd1) begin
      n_fail++;
      $display("FAIL sat_hit: hit=%0d miss=%0d required 3/1", s_hit, s_miss);
    end
    s_flush = 1'b1;
    repeat (15) @(negedge clk);
    n_checks++;
    if (s_miss !== 2'd3 || s_hit !== 2'd3) begin
      n_fail++;
      $display("FAIL sat_miss: hit=%0d miss=%0d required 3/3", s_hit, s_miss);
    end
    s_flush = 1'b0;
    s_f.instr_req_i = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    model_clear();
    test_reset();
    test_cold_miss();
    test_hit_stream();
    test_conflict();
    test_flush();
    test_flush_during_miss();
    test_abort();
    test_reset_mid_miss();
    test_random();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/icache_dm.md
Name: icache_dm

Overview:
- Direct-mapped, read-only instruction cache between the core fetch port and the w25q_spi flash reader.
- Serves hits in one cycle. On a miss, it issues a single-word read on the flash-side instruction interface and fills the line from the returned data.
- Hides the roughly 150-cycle SPI read latency on loops.
- Has a flush input for fence.i, and hit/miss counters for bring-up profiling.

Parameters:
- INDEX_W, 6: number of index bits; the cache holds 2^INDEX_W one-word lines.
- ADDR_W, 24: significant flash address bits; tag = addr[ADDR_W-1:INDEX_W+2].
- CNT_W, 32: width of the performance counters.

Ports:
- clk_i  in  1  clock
- arstn_i  in  1  async active-low reset
- instr_req_i  in  1  core fetch request
- instr_addr_i  in  XLEN  core fetch byte address; word aligned
- instr_rvalid_o  out  1  one-cycle pulse; instr_rdata_o is valid
- instr_rdata_o  out  XLEN  fetched instruction word
- flush_i  in  1  invalidate all lines (one-cycle pulse)
- mem_req_o  out  1  request to the flash reader
- mem_addr_o  out  XLEN  word address sent to the flash reader
- mem_rvalid_i  in  1  flash data valid
- mem_rdata_i  in  XLEN  flash data
- mem_init_i  in  1  flash initialisation finished
- hit_cnt_o  out  CNT_W  saturating hit count
- miss_cnt_o  out  CNT_W  saturating miss count

Behaviour:
- Clock and reset: single clock clk_i; reset is asynchronous, active-low, on arstn_i.
- Reset values: all outputs 0, all valid bits 0, state IDLE, counters 0. Tag and data arrays are not reset.
- States:
  - IDLE: lookup.
  - MISS: mem_req_o high, waiting for flash data.
  - RESP: returning fill data to the core.
- Lookup: combinational on instr_addr_i. hit = valid[idx] && tag[idx] == addr tag.
- IDLE with instr_req_i and a hit:
  - Next cycle: instr_rvalid_o=1, instr_rdata_o=data[idx].
  - Stay in IDLE, so hits sustain 1 word/cycle.
  - hit_cnt_o increments.
- IDLE with instr_req_i and a miss:
  - Latch the address and go to MISS.
  - miss_cnt_o increments.
  - instr_rvalid_o stays 0.
- MISS:
  - mem_req_o is high only while mem_init_i=1. It stays high and mem_addr_o is held stable until mem_rvalid_i; the flash reader aborts if req drops.
  - On mem_rvalid_i: write data and tag, set valid, deassert mem_req_o the same edge, go to RESP.
- RESP:
  - One cycle with instr_rvalid_o=1 and instr_rdata_o=fill data, then IDLE.
  - No lookup is performed in RESP.
- instr_rvalid_o is never high two cycles in a row unless both are hits.
- instr_rdata_o is zeroed when rvalid is low.
- Core protocol: the core holds instr_addr_i and instr_req_i until instr_rvalid_o. It may present a new address in the same cycle rvalid is seen.
- Core drops instr_req_i during MISS: the fill still completes and the line is written, but RESP is skipped (IDLE directly, no rvalid).
- flush_i in IDLE: all valid bits cleared at the edge. A lookup in the same cycle is treated as a miss.
- flush_i during MISS/RESP: valid bits cleared. The in-flight fill returns its data to the core but does not set its valid bit.
- mem_rvalid_i outside MISS is ignored.
- Counters saturate at all-ones and never wrap.
- Reset mid-MISS: state returns to IDLE and mem_req_o drops immediately (async). The flash reader aborts per its own req-drop rule.
- mem_addr_o = {latched addr[XLEN-1:2], 2'b00}.
- Address bits above ADDR_W are ignored by the tag compare.

Decomposition:
- rv_pkg gains:
  - the icache_state_t enum (IDLE, MISS, RESP);
  - constant ICACHE_INDEX_W.
- One sub-module, icache_tag_data: valid/tag/data storage with a combinational read port, a write port and a flush. It is a register array, so it maps to distributed RAM plus flip-flops for valid.

Test Plan:
- Cold miss: mem_init_i=1, req addr 0x100. Required response:
  - mem_req_o high with mem_addr_o=0x100 until a stub returns mem_rvalid_i with 0x00500093 after 150 cycles.
  - Next cycle instr_rvalid_o=1 with rdata 0x00500093.
  - miss_cnt_o=1.
- Hit streaming: after filling 0x100, 0x104 and 0x108, request them back-to-back. Required response: three consecutive rvalid cycles with the correct words, hit_cnt_o=3, mem_req_o stays 0.
- Conflict: with INDEX_W=6, fill 0x100, then request 0x200 (same index, different tag). Required response: miss, refill; then 0x100 misses again. miss_cnt_o=3.
- Flush: fill 0x100, pulse flush_i, request 0x100. Required response: miss and a new mem_req_o.
- Flush during MISS: flush_i mid-fill of 0x40. Required response: the core still gets rvalid with the data; a following request to 0x40 misses.
- Abort and reset:
  - instr_req_i dropped mid-MISS: the fill completes and no rvalid is issued; a subsequent request to the same address is a hit.
  - arstn_i asserted mid-MISS: mem_req_o=0 immediately, all valid bits cleared, counters 0.
